// File: rtl/crc32_stream_pkg.sv
// Shared CRC-32 constants, bit-reflection helpers and FSM state type.
package crc32_stream_pkg;

   localparam int unsigned crc_len     = 32;
   localparam logic [31:0] crc_poly    = 32'h04C11DB7;
   localparam logic [31:0] crc_init    = 32'hFFFFFFFF;
   localparam logic [31:0] crc_residue = 32'hC704DD7B;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [7:0] reflect8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   function automatic logic [31:0] reflect32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = d[31-i];
      return r;
   endfunction

endpackage

// File: rtl/crc32_stream_lane.sv
// One-byte combinational CRC-32 update; passes the accumulator through when en is low.
module crc32_lane
   import crc32_stream_pkg::*;
#(
   parameter logic [31:0] POLY = crc_poly
) (
   input  logic [31:0] acc_in,
   input  logic [7:0]  data,
   input  logic        en,
   output logic [31:0] acc_out
);

   logic [31:0] c;

   // Reflected byte enters at the top, then eight MSB-first division steps
   always_comb begin
      c = acc_in ^ {reflect8(data), 24'h0};
      for (int i = 0; i < 8; i++) begin
         c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      end
      acc_out = en ? c : acc_in;
   end

endmodule

// File: rtl/crc32_stream.sv
// Multi-byte-per-beat Ethernet CRC-32 engine with generate and check modes.
module crc32_stream
   import crc32_stream_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter logic [31:0] POLY   = crc_poly,
   parameter logic [31:0] INIT   = crc_init,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic                  in_valid,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [DATA_W/8-1:0]   in_keep,
   output logic                  crc_valid,
   output logic [31:0]           crc_out,
   output logic                  crc_ok,
   output logic [CNT_W-1:0]      byte_cnt,
   output logic                  frame_err
);

   localparam int unsigned NB = DATA_W / 8;

   state_t             state_q, state_d;
   logic [31:0]        acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               mode_q;

   logic               absorb_c, report_c, stray_c, abort_c, keep_err_c, err_c;
   logic [NB-1:0]      eff_keep_c, lane_en_c;
   logic [CNT_W-1:0]   pop_c, cnt_base_c, cnt_next_c;
   logic [CNT_W:0]     cnt_sum_c;
   logic [31:0]        acc_base_c, acc_next_c;
   logic [NB:0][31:0]  chain;
   logic               frame_mode_c;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (in_valid) begin
         case (state_q)
            ST_IDLE: if (in_sop && !in_eop) state_d = ST_BUSY;
            ST_BUSY: if (in_eop)            state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      absorb_c = in_valid && (in_sop || (state_q == ST_BUSY));
      report_c = absorb_c && in_eop;
      stray_c  = in_valid && !in_sop && (state_q == ST_IDLE);
      abort_c  = in_valid && in_sop && (state_q == ST_BUSY);
   end

   // Keep qualification: eop beats use only lanes below the first cleared bit
   always_comb begin
      logic run;
      run        = 1'b1;
      eff_keep_c = '0;
      for (int k = 0; k < NB; k++) begin
         run           = run & in_keep[k];
         eff_keep_c[k] = run;
      end
      keep_err_c = in_eop ? ((eff_keep_c != in_keep) || (in_keep == '0))
                          : (in_keep != {NB{1'b1}});
      lane_en_c  = absorb_c ? (in_eop ? eff_keep_c : in_keep) : '0;
      err_c      = stray_c || abort_c || (absorb_c && keep_err_c);
   end

   always_comb begin
      pop_c = '0;
      for (int k = 0; k < NB; k++) pop_c = pop_c + CNT_W'(lane_en_c[k]);
      cnt_base_c   = in_sop ? '0 : cnt_q;
      cnt_sum_c    = {1'b0, cnt_base_c} + {1'b0, pop_c};
      cnt_next_c   = cnt_sum_c[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_c[CNT_W-1:0];
      acc_base_c   = in_sop ? INIT : acc_q;
      frame_mode_c = in_sop ? mode : mode_q;
   end

   assign chain[0]   = acc_base_c;
   assign acc_next_c = chain[NB];

   for (genvar k = 0; k < NB; k++) begin : g_lane
      crc32_lane #(.POLY(POLY)) u_lane (
         .acc_in  (chain[k]),
         .data    (in_data[8*k +: 8]),
         .en      (lane_en_c[k]),
         .acc_out (chain[k+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= INIT;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         crc_valid <= 1'b0;
         crc_out   <= '0;
         crc_ok    <= 1'b0;
         byte_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         crc_valid <= report_c;
         frame_err <= err_c;
         if (absorb_c) begin
            acc_q <= acc_next_c;
            cnt_q <= cnt_next_c;
         end
         if (absorb_c && in_sop) mode_q <= mode;
         if (report_c) begin
            crc_out  <= ~reflect32(acc_next_c);
            crc_ok   <= frame_mode_c ? (acc_next_c == crc_residue) : 1'b1;
            byte_cnt <= cnt_next_c;
         end
      end
   end

endmodule

// File: doc/crc32_stream.md
# crc32_stream

Parametrised, multi-byte-per-cycle Ethernet CRC-32 engine for the MAC datapath. Each cycle it absorbs one beat of DATA_W bits with per-byte keep. It frames packets with sop/eop and operates in one of two modes: generate (emit the FCS for TX) or check (compare the residue for RX after the FCS has been streamed through). It replaces the byte-serial CRC path. It sits between the frame assembler / PHY-side deserialiser and the MAC control logic.

## Interface
Parameters:
- DATA_W, 32: beat width in bits. Must be a multiple of 8, in the range 8..64.
- POLY, global::crc_poly (32'h04C11DB7): generator polynomial, normal form.
- INIT, 32'hFFFFFFFF: accumulator seed at sop.
- CNT_W, 16: width of the byte counter.

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- mode, in, 1: 0 = generate, 1 = check. Sampled on the sop beat and held for the whole frame.
- in_valid, in, 1: the beat is present this cycle.
- in_sop, in, 1: first beat of a frame. Qualified by in_valid.
- in_eop, in, 1: last beat of a frame. Qualified by in_valid. sop and eop may both be high on the same beat.
- in_data, in, DATA_W: beat data. Byte lane k = in_data[8k+7:8k]. Lane 0 is first on the wire.
- in_keep, in, DATA_W/8: byte enables. Must be all-ones on non-eop beats. On the eop beat it must be contiguous from lane 0 and non-zero.
- crc_valid, out, 1: one-cycle pulse that reports a frame result.
- crc_out, out, 32: final FCS, ~reflect32(acc). Held until the next crc_valid.
- crc_ok, out, 1: in check mode, acc == 32'hC704DD7B. Forced to 1 in generate mode. Held with crc_out.
- byte_cnt, out, CNT_W: number of bytes absorbed in the reported frame. Saturates at all-ones.
- frame_err, out, 1: one-cycle pulse on a protocol violation.

## Operation
State machine: IDLE, BUSY.

- **IDLE**
  - Beats without sop are ignored and raise frame_err.
  - sop: seed acc with INIT, then absorb the beat, latch mode, and go to BUSY. If eop is on the same beat, report and stay in IDLE.
- **BUSY**
  - Each valid beat updates acc and byte_cnt.
  - eop: report and go to IDLE.
  - sop while BUSY: abort the current frame without reporting, pulse frame_err, and restart from INIT with this beat.
- **Beat update**
  - Lanes are processed in order 0..N-1. Each lane whose keep bit is set applies: reflect8(byte) XOR acc[31:24], then 8 MSB-first shift/XOR steps with POLY.
  - Lanes whose keep bit is clear pass acc through unchanged.
  - byte_cnt += popcount(in_keep).
- **Keep violations**
  - Non-contiguous keep, or zero keep on eop: pulse frame_err and process only the lanes below the first zero bit.
  - Not all-ones on a non-eop beat: pulse frame_err and process the beat anyway.
- **Check mode**: the frame includes its 4 FCS bytes. The residue test uses the unreflected, uncomplemented acc.

## Timing
- Reset values: crc_valid=0, crc_out=0, crc_ok=0, byte_cnt=0, frame_err=0, state=IDLE, acc=INIT.
- Latency: a beat with eop at cycle n gives crc_valid=1 at cycle n+1, with crc_out, crc_ok and byte_cnt valid in that same cycle.
- Throughput: one beat per cycle, back-to-back frames, no backpressure. An eop beat followed immediately by a sop beat is legal and loses no data.
- frame_err is registered and asserted in the cycle after the offending beat.
- in_valid=0 cycles inside a frame hold all state.
- rst in the middle of a frame discards the frame with no crc_valid. The first cycle after reset accepts a new sop.
- The datapath is a single combinational chain of DATA_W/8 byte stages into one register. No pipelining is required at DATA_W ≤ 64.

## Structure
- Package global gains: crc_init (32'hFFFFFFFF), crc_residue (32'hC704DD7B), and the reflect8 and reflect32 functions. crc_poly and crc_len already live there.
- Sub-module crc32_lane: combinational one-byte update (acc_in, byte, en -> acc_out). It is instantiated DATA_W/8 times via generate in crc32_stream.
- The top level holds the FSM, acc register, counter, keep validation and result registers.

## Test plan
- Generate mode, DATA_W=8, "123456789" (0x31..0x39), one byte per beat -> crc_out=32'hCBF43926, byte_cnt=9, crc_ok=1.
- Generate mode, DATA_W=32, same 9 bytes in 3 beats, last keep=4'b0001 -> crc_out=32'hCBF43926, byte_cnt=9. Repeat with in_valid gaps inserted -> same result.
- Check mode, DATA_W=32, "123456789" plus FCS bytes 26 39 F4 CB -> crc_ok=1, byte_cnt=13. Flip one data bit -> crc_ok=0.
- Single beat with sop+eop, DATA_W=8, data 8'h00 -> crc_out=32'hD202EF8D, crc_valid exactly one cycle later.
- sop at cycle 3 while BUSY, then eop at cycle 5 -> frame_err at cycle 4, a single crc_valid at cycle 6 whose CRC covers only the restarted frame.
- Violations and reset:
  - keep=4'b0101 on eop -> frame_err, only lane 0 counted.
  - rst mid-frame -> all outputs at reset values, no crc_valid.
  - a following frame still gives the correct CRC.
